miner_regbank: RTL and testbench
================================

// Module: miner_regbank
// PURPOSE
//  Internal-bus slave directly downstream of the UART command parser.
//  Serves byte read/write requests from the parser and holds the work header, target and control bits for the miner core.
//  Buffers nonces found by the core in a small FIFO that the host drains over the UART.
// PARAMETERS
//  HDR_BYTES   80  header bytes, byte-addressed at 0x000..HDR_BYTES-1 (max 128)
//  FIFO_DEPTH  4   nonce FIFO entries, power of 2, >=2
//  VERSION     8'h11  constant returned at address 0x088
// PORTS
//  clk           input   1    system clock
//  rst           input   1    reset, synchronous, active-low
//  int_address   input   16   byte address from parser
//  int_wr_data   input   8    write byte
//  int_write     input   1    write request qualifier
//  int_read      input   1    read request qualifier
//  int_req       input   1    request valid; held until int_gnt
//  int_gnt       output  1    one-cycle grant
//  int_rd_data   output  8    read byte
//  header        output  8*HDR_BYTES  header bytes; byte 0 at bits [7:0]
//  target        output  32   difficulty target, at addresses 0x0C0..0x0C3, little-endian
//  core_en       output  1    level enable (CTRL bit1)
//  core_start    output  1    one-cycle start pulse
//  core_busy     input   1    core status
//  nonce_vld     input   1    one-cycle nonce-found strobe
//  nonce         input   32   found nonce, sampled when nonce_vld=1
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): all outputs 0; header, target, FIFO pointers and count clear; overflow flag clears.
//  Handshake:
//   - Request accepted on the first cycle with int_req=1 and int_gnt=0.
//   - int_gnt=1 on the next cycle, for exactly one cycle.
//   - Back-to-back: int_gnt is not reasserted on the cycle after a grant.
//   - int_write and int_read both 1: treated as a write.
//  Write: the register updates on the acceptance edge.
//  Read: int_rd_data becomes valid on the grant cycle and holds until the next read grant.
//  Register map:
//   0x000..HDR_BYTES-1  header, RW
//   0x080 CTRL, W
//     bit0  start: core_start pulses once, on the grant cycle
//     bit1  en: level; readback shows bit1 only
//     bit2  fifo_clear: self-clearing
//   0x081 STATUS, R
//     {4'b0, ovf, full, empty, core_busy}
//     Writing 1 to bit3 clears ovf.
//   0x082 COUNT, R: number of FIFO entries (0..FIFO_DEPTH)
//   0x084..0x087 NONCE, R: FIFO head, little-endian
//     Reading 0x087 pops the head, only if not empty.
//     Reading while empty returns 0x00.
//   0x088 VERSION, R
//   All unmapped reads return 0x00; unmapped writes are ignored.
//  FIFO:
//   - nonce_vld while full: entry dropped, ovf set (sticky).
//   - Push and pop on the same cycle:
//       both occur when non-empty;
//       when empty, push only;
//       when full, the push succeeds and ovf stays 0.
//   - fifo_clear in the same cycle as nonce_vld: clear wins, entry lost, ovf unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Reset mid-transaction: pending request dropped; no grant is issued.
//   The parser re-issues the request after reset.
// CONFIGURATION
//  MINER_REGBANK_HASHCNT_EN defined:
//   - Adds input hash_inc (1 bit) and a 32-bit hash counter.
//   - Counter increments on hash_inc, wraps at 2^32, clears on reset or on CTRL bit2.
//   - Reading 0x08C snapshots the counter and returns byte 0; 0x08D..0x08F return snapshot bytes 1..3.
//  Macro not defined: no hash_inc port; 0x08C..0x08F read 0x00.
// TESTING
//  Reset: hold rst=0 for 2 clocks, release; int_gnt=0, core_en=0, all header bytes 0, read 0x081 -> 0x02.
//  Header: write 0xA5 to 0x000 and 0x3C to 0x04F; readback returns the same values; header[7:0]=8'hA5; grant latency exactly 1 cycle.
//  Nonce path: pulse nonce_vld with 0xDEADBEEF; reads 0x084..0x087 -> EF,BE,AD,DE; then COUNT=0, STATUS=0x02.
//  Overflow: 5 nonce strobes with depth 4 -> STATUS=0x0C; write 0x08 to 0x081 -> 0x04; four pops return the first 4 nonces in order.
//  Control: write 0x03 to 0x080 -> core_start high for one cycle, core_en=1; write 0x04 -> FIFO empties, core_en=0.
//  Simultaneous: FIFO full, pop read of 0x087 on the same cycle as nonce_vld -> COUNT stays 4, ovf=0, new nonce at tail.

Source files
------------

// File: rtl/miner_regbank.sv
// Register bank between the UART command parser and the miner core.
// Holds the work header, target and control bits, and buffers found nonces
// in a small FIFO that the host drains byte by byte.
// Optional feature: define MINER_REGBANK_HASHCNT_EN to add the hash_inc input
// and a 32-bit hash counter readable at 0x08C..0x08F.
module miner_regbank #(
    parameter int unsigned HDR_BYTES  = 80,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  VERSION    = 8'h11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            int_address,
    input  logic [7:0]             int_wr_data,
    input  logic                   int_write,
    input  logic                   int_read,
    input  logic                   int_req,
    output logic                   int_gnt,
    output logic [7:0]             int_rd_data,
    output logic [8*HDR_BYTES-1:0] header,
    output logic [31:0]            target,
    output logic                   core_en,
    output logic                   core_start,
    input  logic                   core_busy,
    input  logic                   nonce_vld,
    input  logic [31:0]            nonce
`ifdef MINER_REGBANK_HASHCNT_EN
    ,
    input  logic                   hash_inc
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [15:0] AddrCtrl    = 16'h0080;
    localparam logic [15:0] AddrStatus  = 16'h0081;
    localparam logic [15:0] AddrCount   = 16'h0082;
    localparam logic [15:0] AddrNoncePop = 16'h0087;
    localparam logic [15:0] AddrVersion = 16'h0088;

    // Register state
    logic                   gnt_q;
    logic [7:0]             rd_data_q;
    logic [8*HDR_BYTES-1:0] header_q;
    logic [31:0]            target_q;
    logic                   en_q;
    logic                   start_q;
    logic                   ovf_q, ovf_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [31:0]            fifo_mem [FIFO_DEPTH];

    // Decode
    logic       accept, wr_acc, rd_acc;
    logic       hdr_hit, tgt_hit, nonce_hit;
    logic [9:0] hdr_lsb;
    logic [4:0] byte_lsb;
    logic       ctrl_wr, fifo_clr, status_wr;
    logic       full, empty, pop, push;
    logic [31:0] head;
    logic [7:0] rd_byte;

    // A request is taken only when no grant is showing, so grants never run back-to-back
    assign accept    = int_req & ~gnt_q;
    assign wr_acc    = accept & int_write;
    assign rd_acc    = accept & int_read & ~int_write;

    assign hdr_hit   = int_address < 16'(HDR_BYTES);
    assign hdr_lsb   = {int_address[6:0], 3'b000};
    assign byte_lsb  = {int_address[1:0], 3'b000};
    assign tgt_hit   = int_address[15:2] == 14'h0030;
    assign nonce_hit = int_address[15:2] == 14'h0021;

    assign ctrl_wr   = wr_acc && (int_address == AddrCtrl);
    assign fifo_clr  = ctrl_wr && int_wr_data[2];
    assign status_wr = wr_acc && (int_address == AddrStatus);

    assign full      = count_q == CntW'(FIFO_DEPTH);
    assign empty     = count_q == '0;
    assign head      = fifo_mem[rd_ptr_q];
    assign pop       = rd_acc && (int_address == AddrNoncePop) && !empty;

`ifdef MINER_REGBANK_HASHCNT_EN
    logic        hash_hit;
    logic [31:0] hash_cnt_q;
    logic [31:0] hash_snap_q;

    assign hash_hit = int_address[15:2] == 14'h0023;

    // Hash counter and the snapshot taken when byte 0 is read
    always_ff @(posedge clk) begin
        if (!rst) begin
            hash_cnt_q  <= '0;
            hash_snap_q <= '0;
        end else begin
            if (fifo_clr) begin
                hash_cnt_q <= '0;
            end else if (hash_inc) begin
                hash_cnt_q <= hash_cnt_q + 32'd1;
            end
            if (rd_acc && hash_hit && (int_address[1:0] == 2'd0)) begin
                hash_snap_q <= hash_cnt_q;
            end
        end
    end
`endif

    // Read data mux; unmapped addresses return zero
    always_comb begin
        rd_byte = 8'h00;
        if (hdr_hit) begin
            rd_byte = header_q[hdr_lsb +: 8];
        end else if (tgt_hit) begin
            rd_byte = target_q[byte_lsb +: 8];
        end else if (nonce_hit) begin
            if (!empty) begin
                rd_byte = head[byte_lsb +: 8];
            end
`ifdef MINER_REGBANK_HASHCNT_EN
        end else if (hash_hit) begin
            // Byte 0 comes live from the counter; the rest from the snapshot it loads
            if (int_address[1:0] == 2'd0) begin
                rd_byte = hash_cnt_q[7:0];
            end else begin
                rd_byte = hash_snap_q[byte_lsb +: 8];
            end
`endif
        end else begin
            case (int_address)
                AddrCtrl:    rd_byte = {6'b0, en_q, 1'b0};
                AddrStatus:  rd_byte = {4'b0, ovf_q, full, empty, core_busy};
                AddrCount:   rd_byte = 8'(count_q);
                AddrVersion: rd_byte = VERSION;
                default:     rd_byte = 8'h00;
            endcase
        end
    end

    // FIFO next state: clear beats push/pop; a push into a full FIFO survives only alongside a pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
        if (status_wr && int_wr_data[3]) begin
            ovf_d = 1'b0;
        end
        if (fifo_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            push = nonce_vld && (!full || pop);
            if (nonce_vld && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= nonce;
        end
    end

    // Bus handshake, register writes and FIFO state
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_q     <= 1'b0;
            rd_data_q <= 8'h00;
            header_q  <= '0;
            target_q  <= '0;
            en_q      <= 1'b0;
            start_q   <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            gnt_q    <= accept;
            start_q  <= ctrl_wr && int_wr_data[0];
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (rd_acc) begin
                rd_data_q <= rd_byte;
            end
            if (wr_acc && hdr_hit) begin
                header_q[hdr_lsb +: 8] <= int_wr_data;
            end
            if (wr_acc && tgt_hit) begin
                target_q[byte_lsb +: 8] <= int_wr_data;
            end
            if (ctrl_wr) begin
                en_q <= int_wr_data[1];
            end
        end
    end

    assign int_gnt     = gnt_q;
    assign int_rd_data = rd_data_q;
    assign header      = header_q;
    assign target      = target_q;
    assign core_en     = en_q;
    assign core_start  = start_q;

endmodule

// File: tb/tb_miner_regbank.sv
// Directed bench for miner_regbank: reset, header/target access, nonce FIFO,
// overflow, control bits, simultaneous push/pop and reset mid-request.
module tb_miner_regbank;

    localparam int unsigned HdrBytes = 80;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [15:0]           int_address = '0;
    logic [7:0]            int_wr_data = '0;
    logic                  int_write = 1'b0;
    logic                  int_read = 1'b0;
    logic                  int_req = 1'b0;
    logic                  int_gnt;
    logic [7:0]            int_rd_data;
    logic [8*HdrBytes-1:0] header;
    logic [31:0]           target;
    logic                  core_en;
    logic                  core_start;
    logic                  core_busy = 1'b0;
    logic                  nonce_vld = 1'b0;
    logic [31:0]           nonce = '0;
`ifdef MINER_REGBANK_HASHCNT_EN
    logic                  hash_inc = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int last_lat;
    logic last_start;

    miner_regbank #(
        .HDR_BYTES (HdrBytes),
        .FIFO_DEPTH(4),
        .VERSION   (8'h11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .int_address(int_address),
        .int_wr_data(int_wr_data),
        .int_write  (int_write),
        .int_read   (int_read),
        .int_req    (int_req),
        .int_gnt    (int_gnt),
        .int_rd_data(int_rd_data),
        .header     (header),
        .target     (target),
        .core_en    (core_en),
        .core_start (core_start),
        .core_busy  (core_busy),
        .nonce_vld  (nonce_vld),
        .nonce      (nonce)
`ifdef MINER_REGBANK_HASHCNT_EN
        ,
        .hash_inc   (hash_inc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the grant, then leave one idle cycle
    task automatic bus_op(input logic [15:0] a, input logic [7:0] d, input logic wr,
                          output logic [7:0] rdata);
        int n;
        int_address = a;
        int_wr_data = d;
        int_write   = wr;
        int_read    = ~wr;
        int_req     = 1'b1;
        n = 0;
        @(posedge clk); #1;
        while (!int_gnt && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("grant_seen", {31'b0, int_gnt}, 32'd1);
        last_lat   = n;
        last_start = core_start;
        rdata      = int_rd_data;
        int_req    = 1'b0;
        int_write  = 1'b0;
        int_read   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] unused;
        bus_op(a, d, 1'b1, unused);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        bus_op(a, 8'h00, 1'b0, d);
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, {24'b0, d}, {24'b0, exp});
    endtask

    // Read 0x084..0x087 as one word; the last byte pops the FIFO
    task automatic read_nonce(output logic [31:0] w);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            bus_read(16'h0084 + 16'(i), b);
            w[8*i +: 8] = b;
        end
    endtask

    task automatic pulse_nonce(input logic [31:0] v);
        nonce     = v;
        nonce_vld = 1'b1;
        @(posedge clk); #1;
        nonce_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] vals [5];
        vals[0] = 32'h1111_0001;
        vals[1] = 32'h2222_0002;
        vals[2] = 32'h3333_0003;
        vals[3] = 32'h4444_0004;
        vals[4] = 32'h5555_0005;

        // Reset
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        check("rst_gnt", {31'b0, int_gnt}, 32'd0);
        check("rst_core_en", {31'b0, core_en}, 32'd0);
        check("rst_core_start", {31'b0, core_start}, 32'd0);
        check("rst_header_zero", {31'b0, header == '0}, 32'd1);
        check("rst_target", target, 32'd0);
        read_check("rst_status", 16'h0081, 8'h02);
        read_check("rst_count", 16'h0082, 8'h00);

        // Header access and grant latency
        bus_write(16'h0000, 8'hA5);
        check("hdr_wr_latency", last_lat, 32'd0);
        bus_write(16'h004F, 8'h3C);
        read_check("hdr_rd_0", 16'h0000, 8'hA5);
        check("hdr_rd_latency", last_lat, 32'd0);
        read_check("hdr_rd_4f", 16'h004F, 8'h3C);
        check("hdr_out_0", {24'b0, header[7:0]}, 32'hA5);
        check("hdr_out_4f", {24'b0, header[8*79 +: 8]}, 32'h3C);
        read_check("hdr_beyond", 16'h0050, 8'h00);

        // Request held through the grant: no grant on the following cycle
        int_address = 16'h0001;
        int_wr_data = 8'h5A;
        int_write   = 1'b1;
        int_req     = 1'b1;
        @(posedge clk); #1;
        check("b2b_grant", {31'b0, int_gnt}, 32'd1);
        @(posedge clk); #1;
        check("b2b_no_regrant", {31'b0, int_gnt}, 32'd0);
        int_req   = 1'b0;
        int_write = 1'b0;
        @(posedge clk); #1;
        check("b2b_hdr_1", {24'b0, header[15:8]}, 32'h5A);

        // Target, version, unmapped, core_busy
        bus_write(16'h00C0, 8'h78);
        bus_write(16'h00C1, 8'h56);
        bus_write(16'h00C2, 8'h34);
        bus_write(16'h00C3, 8'h12);
        check("target", target, 32'h1234_5678);
        read_check("target_rd", 16'h00C2, 8'h34);
        read_check("version", 16'h0088, 8'h11);
        read_check("unmapped", 16'h0090, 8'h00);
`ifndef MINER_REGBANK_HASHCNT_EN
        read_check("hash_absent", 16'h008C, 8'h00);
`endif
        core_busy = 1'b1;
        read_check("status_busy", 16'h0081, 8'h03);
        core_busy = 1'b0;

        // Nonce path
        pulse_nonce(32'hDEAD_BEEF);
        read_check("count_one", 16'h0082, 8'h01);
        read_check("nonce_b0", 16'h0084, 8'hEF);
        read_check("nonce_b1", 16'h0085, 8'hBE);
        read_check("nonce_b2", 16'h0086, 8'hAD);
        read_check("nonce_b3", 16'h0087, 8'hDE);
        read_check("count_after_pop", 16'h0082, 8'h00);
        read_check("status_after_pop", 16'h0081, 8'h02);
        read_check("nonce_empty", 16'h0087, 8'h00);
        read_check("count_empty_pop", 16'h0082, 8'h00);

        // Overflow
        for (int i = 0; i < 5; i++) pulse_nonce(vals[i]);
        read_check("ovf_status", 16'h0081, 8'h0C);
        read_check("ovf_count", 16'h0082, 8'h04);
        bus_write(16'h0081, 8'h08);
        read_check("ovf_cleared", 16'h0081, 8'h04);
        for (int i = 0; i < 4; i++) begin
            read_nonce(w);
            check("ovf_pop_order", w, vals[i]);
        end
        read_check("ovf_drained", 16'h0081, 8'h02);

        // Control
        bus_write(16'h0080, 8'h03);
        check("start_on_grant", {31'b0, last_start}, 32'd1);
        check("start_one_cycle", {31'b0, core_start}, 32'd0);
        check("en_set", {31'b0, core_en}, 32'd1);
        read_check("ctrl_readback", 16'h0080, 8'h02);
        pulse_nonce(32'hCAFE_F00D);
        read_check("count_before_clr", 16'h0082, 8'h01);
        bus_write(16'h0080, 8'h04);
        check("start_no_pulse", {31'b0, last_start}, 32'd0);
        check("en_clear", {31'b0, core_en}, 32'd0);
        read_check("count_after_clr", 16'h0082, 8'h00);
        read_check("status_after_clr", 16'h0081, 8'h02);

        // Simultaneous pop and push while full
        for (int i = 0; i < 4; i++) pulse_nonce(32'hA000_0000 + 32'(i));
        int_address = 16'h0087;
        int_read    = 1'b1;
        int_req     = 1'b1;
        nonce       = 32'hA000_0004;
        nonce_vld   = 1'b1;
        @(posedge clk); #1;
        nonce_vld = 1'b0;
        check("sim_grant", {31'b0, int_gnt}, 32'd1);
        check("sim_rd_data", {24'b0, int_rd_data}, 32'hA0);
        int_req  = 1'b0;
        int_read = 1'b0;
        @(posedge clk); #1;
        read_check("sim_count", 16'h0082, 8'h04);
        read_check("sim_status", 16'h0081, 8'h04);
        for (int i = 1; i < 5; i++) begin
            read_nonce(w);
            check("sim_pop_order", w, 32'hA000_0000 + 32'(i));
        end

        // Reset mid-request: no grant, state cleared
        int_address = 16'h0000;
        int_wr_data = 8'h77;
        int_write   = 1'b1;
        int_req     = 1'b1;
        rst         = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_no_gnt", {31'b0, int_gnt}, 32'd0);
        int_req   = 1'b0;
        int_write = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_no_gnt2", {31'b0, int_gnt}, 32'd0);
        check("rst_mid_hdr", {24'b0, header[7:0]}, 32'h00);
        check("rst_mid_target", target, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
